// File: rtl/sub_nib_engine.sv
// Multi-cycle S-AES nibble-substitution engine.
// Substitutes LANES nibbles per clock, lowest group first, with valid/ready on both sides.
// Optional build macro SUBNIB_ROTNIB_EN adds a rot input that swaps word halves at accept.
module sub_nib_engine #(
    parameter int unsigned NIBBLES = 4,
    parameter int unsigned LANES   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   din,
    input  logic                   inv,
    output logic                   out_valid,
    input  logic                   out_ready,
`ifdef SUBNIB_ROTNIB_EN
    input  logic                   rot,
`endif
    output logic [4*NIBBLES-1:0]   dout
);

    localparam int unsigned W      = 4 * NIBBLES;
    // Guarded so a bad LANES reaches the elaboration error below instead of dividing by zero.
    localparam int unsigned GROUPS = (LANES != 0) ? NIBBLES / LANES : 1;
    localparam int unsigned GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    if (NIBBLES < 1) begin : g_bad_nibbles
        $error("sub_nib_engine: NIBBLES must be >= 1");
    end
    if (LANES < 1 || (LANES != 0 && (NIBBLES % LANES) != 0)) begin : g_bad_lanes
        $error("sub_nib_engine: LANES must divide NIBBLES");
    end
`ifdef SUBNIB_ROTNIB_EN
    if ((NIBBLES % 2) != 0) begin : g_bad_rot
        $error("sub_nib_engine: RotNib needs an even NIBBLES");
    end
`endif

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    data_q, data_d;
    logic [GW-1:0]   grp_q, grp_d;
    logic            inv_q, inv_d;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    latch_word;

    function automatic logic [3:0] sbox(input logic [3:0] x, input logic inverse);
        logic [3:0] f;
        logic [3:0] r;
        case (x)
            4'h0: begin f = 4'h9; r = 4'hA; end
            4'h1: begin f = 4'h4; r = 4'h5; end
            4'h2: begin f = 4'hA; r = 4'h9; end
            4'h3: begin f = 4'hB; r = 4'hB; end
            4'h4: begin f = 4'hD; r = 4'h1; end
            4'h5: begin f = 4'h1; r = 4'h7; end
            4'h6: begin f = 4'h8; r = 4'h8; end
            4'h7: begin f = 4'h5; r = 4'hF; end
            4'h8: begin f = 4'h6; r = 4'h6; end
            4'h9: begin f = 4'h2; r = 4'h0; end
            4'hA: begin f = 4'h0; r = 4'h2; end
            4'hB: begin f = 4'h3; r = 4'h3; end
            4'hC: begin f = 4'hC; r = 4'hC; end
            4'hD: begin f = 4'hE; r = 4'h4; end
            4'hE: begin f = 4'hF; r = 4'hD; end
            default: begin f = 4'h7; r = 4'hE; end
        endcase
        return inverse ? r : f;
    endfunction

    // Word as it enters the data register; RotNib swaps halves here so it costs no cycle.
    always_comb begin
        latch_word = din;
`ifdef SUBNIB_ROTNIB_EN
        if (rot) begin
            latch_word = {din[W/2-1:0], din[W-1:W/2]};
        end
`endif
    end

    // Next-state: accept in IDLE, one nibble group per clock in BUSY, hold in DONE.
    always_comb begin
        int unsigned base;
        state_d     = state_q;
        data_d      = data_q;
        grp_d       = grp_q;
        inv_d       = inv_q;
        out_valid_d = out_valid_q;
        base        = 32'(grp_q) * LANES;
        if (flush) begin
            // Data register is left alone so dout keeps its last value.
            state_d     = StIdle;
            out_valid_d = 1'b0;
            grp_d       = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        data_d  = latch_word;
                        inv_d   = inv;
                        grp_d   = '0;
                        state_d = StBusy;
                    end
                end
                StBusy: begin
                    for (int unsigned l = 0; l < LANES; l++) begin
                        data_d[(base + l) * 4 +: 4] = sbox(data_q[(base + l) * 4 +: 4], inv_q);
                    end
                    grp_d = grp_q + GW'(1);
                    if (grp_q == GW'(GROUPS - 1)) begin
                        grp_d       = '0;
                        state_d     = StDone;
                        out_valid_d = 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and datapath registers; reset loses any word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            data_q      <= '0;
            grp_q       <= '0;
            inv_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            grp_q       <= grp_d;
            inv_q       <= inv_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign dout      = data_q;

endmodule

// File: tb/tb_sub_nib_engine.sv
// Scoreboard bench for sub_nib_engine: driver pushes expected words, monitor pops on output.
module tb_sub_nib_engine;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, inv, out_ready, rot;
    logic [15:0] din;
    logic        in_ready, out_valid;
    logic [15:0] dout;

    // Secondary instances for the parameter sweep.
    logic       b_valid, b_ready, b_ovalid, c_valid, c_inv, c_ready, c_ovalid, zero;
    logic [7:0] b_din, b_dout;
    logic [15:0] c_din, c_dout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] data;
        int          acc;
        int          lat;
    } exp_t;
    exp_t q[$];

    logic [3:0] fwd_t [16] = '{4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
                               4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sub_nib_engine #(.NIBBLES(4), .LANES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .inv       (inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef SUBNIB_ROTNIB_EN
        .rot       (rot),
`endif
        .dout      (dout)
    );

    sub_nib_engine #(.NIBBLES(2), .LANES(2)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (zero),
        .in_valid  (b_valid),
        .in_ready  (b_ready),
        .din       (b_din),
        .inv       (zero),
        .out_valid (b_ovalid),
        .out_ready (1'b1),
`ifdef SUBNIB_ROTNIB_EN
        .rot       (zero),
`endif
        .dout      (b_dout)
    );

    sub_nib_engine #(.NIBBLES(4), .LANES(1)) dut_c (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (zero),
        .in_valid  (c_valid),
        .in_ready  (c_ready),
        .din       (c_din),
        .inv       (c_inv),
        .out_valid (c_ovalid),
        .out_ready (1'b1),
`ifdef SUBNIB_ROTNIB_EN
        .rot       (zero),
`endif
        .dout      (c_dout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Issue one word on the main DUT; optionally queue the expected result.
    task automatic send(input logic [15:0] d, input logic m, input logic r,
                        input logic [15:0] exp_data, input bit push);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        din      = d;
        inv      = m;
        rot      = r;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rot      = 1'b0;
        if (push) q.push_back('{data: exp_data, acc: cyc, lat: 2});
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", 32'(q.size()), 32'd0);
    endtask

    function automatic logic [15:0] fwd_word(input logic [15:0] x);
        logic [15:0] y;
        for (int i = 0; i < 4; i++) y[i*4 +: 4] = fwd_t[x[i*4 +: 4]];
        return y;
    endfunction

    // Monitor: latency on the rising edge of out_valid, data on the handshake.
    initial begin
        logic ov_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid && !ov_prev) begin
                if (q.size() == 0) check("spurious_out_valid", 32'(out_valid), 32'd0);
                else check("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
            end
            if (out_valid && out_ready && q.size() > 0) begin
                check("dout", 32'(dout), 32'(q[0].data));
                void'(q.pop_front());
            end
            ov_prev = out_valid;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] x, hold;
        int n, a;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; inv = 1'b0; out_ready = 1'b1;
        rot = 1'b0; din = '0; zero = 1'b0;
        b_valid = 1'b0; b_din = '0; c_valid = 1'b0; c_din = '0; c_inv = 1'b0;
        #22 rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_dout", 32'(dout), 32'h0);

        // Directed forward / inverse.
        send(16'h1234, 1'b0, 1'b0, 16'h4ABD, 1'b1);
        send(16'h4ABD, 1'b1, 1'b0, 16'h1234, 1'b1);
        drain();

        // All nibble values in every lane, forward then inverse back.
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 4; k++) x[k*4 +: 4] = 4'(i + k);
            send(x, 1'b0, 1'b0, fwd_word(x), 1'b1);
            send(fwd_word(x), 1'b1, 1'b0, x, 1'b1);
        end
        drain();

        // Backpressure: output held, extra input ignored.
        out_ready = 1'b0;
        send(16'h0F3C, 1'b0, 1'b0, 16'h97BC, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_out_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            din      = 16'h5555;
            check("bp_dout_stable", 32'(dout), 32'h97BC);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_in_ready_after", 32'(in_ready), 32'd1);
        check("bp_out_valid_after", 32'(out_valid), 32'd0);
        drain();

        // Flush one edge into BUSY.
        send(16'h1234, 1'b0, 1'b0, 16'h0, 1'b0);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_in_ready", 32'(in_ready), 32'd1);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        // Flush with in_valid in IDLE must not accept.
        flush = 1'b1; in_valid = 1'b1; din = 16'hAAAA;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_no_accept", 32'(in_ready), 32'd1);
        repeat (5) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of BUSY.
        send(16'h1234, 1'b0, 1'b0, 16'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_dout", 32'(dout), 32'h0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        hold = dout;
        check("arst_dout_hold", 32'(hold), 32'h0);

        // Engine recovers after reset.
        send(16'hA5F0, 1'b0, 1'b0, 16'h0179, 1'b1);
        drain();

`ifdef SUBNIB_ROTNIB_EN
        send(16'h1234, 1'b0, 1'b1, 16'hBD4A, 1'b1);
        send(16'h1234, 1'b0, 1'b0, 16'h4ABD, 1'b1);
        drain();
`endif

        // NIBBLES=2, LANES=2: single-edge BUSY.
        check("b_in_ready", 32'(b_ready), 32'd1);
        b_valid = 1'b1; b_din = 8'h2D;
        @(posedge clk); #1;
        a = cyc; b_valid = 1'b0;
        n = 0;
        while (!b_ovalid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("b_latency", 32'(cyc - a), 32'd1);
        check("b_dout", 32'(b_dout), 32'hAE);

        // NIBBLES=4, LANES=1: four-edge BUSY, forward then inverse.
        for (int m = 0; m < 2; m++) begin
            check("c_in_ready", 32'(c_ready), 32'd1);
            c_valid = 1'b1;
            c_din   = (m == 0) ? 16'h1234 : 16'h4ABD;
            c_inv   = (m != 0);
            @(posedge clk); #1;
            a = cyc; c_valid = 1'b0;
            n = 0;
            while (!c_ovalid && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            check("c_latency", 32'(cyc - a), 32'd4);
            check("c_dout", 32'(c_dout), (m == 0) ? 32'h4ABD : 32'h1234);
            @(posedge clk); #1;
        end

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sub_nib_engine.md
Name: sub_nib_engine

Overview:
- Parametrised, multi-cycle nibble-substitution engine for the S-AES datapath.
- Applies the S-AES S-box, forward or inverse, to every nibble of an N-nibble word.
- Uses LANES S-box instances per clock, with valid/ready handshakes on input and output.
- Shared by the round function (SubNib on the 16-bit state) and key expansion (8-bit words).

Parameters:
NIBBLES, 4, nibbles per word; word width W = 4*NIBBLES; must be >= 1.
LANES, 2, nibbles substituted per clock; must divide NIBBLES, else elaboration error.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous abort; returns the FSM to IDLE and drops the word in flight.
in_valid  input  1  din/inv valid.
in_ready  output  1  engine can accept a word.
din  input  W  word to substitute.
inv  input  1  0 = forward S-box, 1 = inverse S-box; sampled at accept.
out_valid  output  1  dout holds a finished word.
out_ready  input  1  consumer accepts dout.
dout  output  W  substituted word.
rot  input  1  present only with SUBNIB_ROTNIB_EN; see Optional Feature.

Behaviour:
- Forward S-box, nibble 0..F → 9,4,A,B,D,1,8,5,6,2,0,3,C,E,F,7.
- Inverse S-box, nibble 0..F → A,5,9,B,1,7,8,F,6,0,2,3,C,4,D,E.
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- Reset values: data register 0, group counter 0, mode bit 0, dout 0, out_valid 0.
- in_ready = (state == IDLE); it is therefore 1 immediately after reset release.
- IDLE: on in_valid & in_ready at a clock edge:
  - latch din into the data register;
  - latch inv into the mode bit;
  - clear the group counter;
  - go to BUSY.
- BUSY: each clock, replace nibble group g with its substituted value.
  - Group g = nibbles [g*LANES .. g*LANES+LANES-1], taken from the least-significant group upward.
  - Increment g.
  - At the edge that processes group NIBBLES/LANES-1, go to DONE and set out_valid = 1.
- Latency: out_valid rises NIBBLES/LANES clock edges after the accept edge. With defaults this is 2.
- DONE:
  - dout and out_valid hold stable until out_valid & out_ready at an edge.
  - Then clear out_valid and go to IDLE.
  - No same-cycle re-accept: in_ready rises the cycle after the handshake.
- Throughput: 1 word per NIBBLES/LANES + 2 clocks when out_ready is held high.
- in_valid, din and inv are ignored outside IDLE.
- Edge case LANES == NIBBLES: BUSY lasts a single edge.
- flush: overrides all other activity from any state.
  - Next edge: state IDLE, out_valid 0, counter 0.
  - dout keeps its last value.
  - flush with in_valid in IDLE: no accept.
- Reset asserted mid-operation: all registers clear immediately. The word is lost; no partial output is presented.
- dout is undefined/don't-care while out_valid = 0. It is driven from the data register.

Optional Feature:
- Macro: SUBNIB_ROTNIB_EN.
- When defined:
  - The rot port exists and is sampled at accept.
  - rot = 1 rotates the latched word by W/2 bits (swaps upper and lower halves) before substitution. This is RotNib for key expansion.
  - The rotation is applied at the accept edge and adds no latency.
  - NIBBLES must be even, else elaboration error.
- When undefined: no rot port; the word is latched unmodified.

Test Plan:
- Forward, NIBBLES=4, LANES=2, din=0x1234, inv=0 → out_valid exactly 2 edges after accept; dout=0x4ABD.
- Inverse: din=0x4ABD, inv=1 → dout=0x1234. Sweep all 16 nibble values through both modes; inverse(forward(x)) == x.
- Backpressure: out_ready low for 5 cycles after out_valid → dout stable, in_ready 0, a second in_valid is ignored; out_ready high → next cycle in_ready=1.
- Flush in BUSY after 1 edge → next cycle IDLE, in_ready=1, out_valid never asserted. Async rst_n pulse in BUSY → outputs 0 immediately.
- Parameter sweep NIBBLES=2/LANES=2 (din=0x2D → 0xAE, latency 1) and NIBBLES=4/LANES=1 (latency 4, same results as above).
- SUBNIB_ROTNIB_EN defined, din=0x1234, rot=1, inv=0 → dout=0xBD4A. With rot=0 → 0x4ABD.
